// File: rtl/mem_access.sv
// mem_access: memory-access stage of the five-stage RISC-V pipeline.
// Issues word loads/stores over a valid/ready channel and builds the registered WB record.
package mem_access_pkg;
  typedef struct packed {
    logic        mem_read;
    logic        mem_write;
    logic        reg_write;
    logic [4:0]  rd;
    logic [31:0] alu_result;
    logic [31:0] mem_data;
    logic        is_final;
  } ex_to_mem_s;
endpackage

module mem_access
  import mem_access_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  ex_to_mem_s  ex_to_mem,
  output logic        stall,
  output logic [31:0] bp_mem,
  output logic        dmem_req_valid,
  input  logic        dmem_req_ready,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_rsp_valid,
  input  logic [31:0] dmem_rdata,
  output logic        wb_valid,
  output logic        wb_reg_write,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        wb_is_final,
  output logic        misalign_err,
  output logic        timeout_err
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RSP  = 2'd2
  } state_e;

  state_e           state_r;
  state_e           state_nxt_s;
  logic [CNT_W-1:0] cnt_r;

  logic        cap_reg_write_r;
  logic [4:0]  cap_rd_r;
  logic        cap_is_final_r;
  logic [31:0] cap_addr_r;
  logic [31:0] cap_wdata_r;
  logic        cap_we_r;

  logic        mem_op_s;
  logic        is_load_s;
  logic        misalign_s;
  logic        timeout_s;
  logic        capture_s;
  logic        req_valid_s;
  logic        done_s;
  logic        abort_s;
  logic        wb_reg_write_nxt_s;
  logic [4:0]  wb_rd_nxt_s;
  logic [31:0] wb_data_nxt_s;
  logic        wb_is_final_nxt_s;

  assign mem_op_s   = ex_to_mem.mem_read | ex_to_mem.mem_write;
  assign is_load_s  = ex_to_mem.mem_read;
  assign misalign_s = mem_op_s && (ex_to_mem.alu_result[1:0] != 2'b00);
  assign timeout_s  = (state_r != ST_IDLE) && (cnt_r == CNT_MAX);
  assign capture_s  = (state_r == ST_IDLE) && mem_op_s && !misalign_s;

  assign bp_mem         = ex_to_mem.alu_result;
  // Reset must silence the request and stall at once, even with a memory op held on the input.
  assign dmem_req_valid = req_valid_s && !rst;
  assign stall          = !rst && !done_s;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= ST_IDLE;
    else     state_r <= state_nxt_s;
  end

  // Next-state logic; a real handshake/response wins over a timeout in the same cycle.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (capture_s) begin
          if (!dmem_req_ready)  state_nxt_s = ST_REQ;
          else if (is_load_s)   state_nxt_s = ST_RSP;
          else                  state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (dmem_req_ready)  state_nxt_s = cap_we_r ? ST_IDLE : ST_RSP;
        else if (timeout_s)  state_nxt_s = ST_IDLE;
        else                 state_nxt_s = ST_REQ;
      end
      ST_RSP: begin
        if (dmem_rsp_valid || timeout_s) state_nxt_s = ST_IDLE;
        else                             state_nxt_s = ST_RSP;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Request channel, retirement decision and next WB record.
  always_comb begin
    req_valid_s        = 1'b0;
    dmem_we            = !is_load_s;
    dmem_addr          = {ex_to_mem.alu_result[31:2], 2'b00};
    dmem_wdata         = ex_to_mem.mem_data;
    done_s             = 1'b0;
    abort_s            = 1'b0;
    wb_reg_write_nxt_s = 1'b0;
    wb_rd_nxt_s        = ex_to_mem.rd;
    wb_data_nxt_s      = ex_to_mem.alu_result;
    wb_is_final_nxt_s  = ex_to_mem.is_final;
    case (state_r)
      ST_IDLE: begin
        if (!mem_op_s) begin
          done_s             = 1'b1;
          wb_reg_write_nxt_s = ex_to_mem.reg_write;
        end else if (misalign_s) begin
          done_s = 1'b1;
        end else begin
          req_valid_s = 1'b1;
          done_s      = dmem_req_ready && !is_load_s;
        end
      end
      ST_REQ: begin
        req_valid_s       = 1'b1;
        dmem_we           = cap_we_r;
        dmem_addr         = cap_addr_r;
        dmem_wdata        = cap_wdata_r;
        wb_rd_nxt_s       = cap_rd_r;
        wb_is_final_nxt_s = cap_is_final_r;
        if (dmem_req_ready) begin
          done_s = cap_we_r;
        end else if (timeout_s) begin
          done_s  = 1'b1;
          abort_s = 1'b1;
        end else begin
          done_s = 1'b0;
        end
      end
      ST_RSP: begin
        wb_rd_nxt_s       = cap_rd_r;
        wb_is_final_nxt_s = cap_is_final_r;
        if (dmem_rsp_valid) begin
          done_s             = 1'b1;
          wb_reg_write_nxt_s = cap_reg_write_r;
          wb_data_nxt_s      = dmem_rdata;
        end else if (timeout_s) begin
          done_s  = 1'b1;
          abort_s = 1'b1;
        end else begin
          done_s = 1'b0;
        end
      end
      default: begin
        done_s = 1'b0;
      end
    endcase
  end

  // Wait counter: zero in IDLE, counts REQ/RSP cycles and saturates at the limit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      cnt_r <= '0;
    else if (state_r == ST_IDLE)  cnt_r <= '0;
    else if (cnt_r != CNT_MAX)    cnt_r <= cnt_r + CNT_W'(1);
    else                          cnt_r <= cnt_r;
  end

  // Capture the aligned memory op as it leaves IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_reg_write_r <= 1'b0;
      cap_rd_r        <= 5'd0;
      cap_is_final_r  <= 1'b0;
      cap_addr_r      <= 32'd0;
      cap_wdata_r     <= 32'd0;
      cap_we_r        <= 1'b0;
    end else if (capture_s) begin
      cap_reg_write_r <= ex_to_mem.reg_write;
      cap_rd_r        <= ex_to_mem.rd;
      cap_is_final_r  <= ex_to_mem.is_final;
      cap_addr_r      <= {ex_to_mem.alu_result[31:2], 2'b00};
      cap_wdata_r     <= ex_to_mem.mem_data;
      cap_we_r        <= !is_load_s;
    end
  end

  // WB record: bubbles clear valid/write-enable and keep the last payload.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_valid     <= 1'b0;
      wb_reg_write <= 1'b0;
      wb_rd        <= 5'd0;
      wb_data      <= 32'd0;
      wb_is_final  <= 1'b0;
    end else begin
      wb_valid     <= done_s;
      wb_reg_write <= wb_reg_write_nxt_s;
      if (done_s) begin
        wb_rd       <= wb_rd_nxt_s;
        wb_data     <= wb_data_nxt_s;
        wb_is_final <= wb_is_final_nxt_s;
      end
    end
  end

  // Sticky error flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      misalign_err <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      misalign_err <= misalign_err | ((state_r == ST_IDLE) && misalign_s);
      timeout_err  <= timeout_err | abort_s;
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: directed stimulus with a WB scoreboard for mem_access.
// Expected retirements are queued at issue; a negedge monitor pops them on wb_valid.
module tb_mem_access;
  import mem_access_pkg::*;

  logic        clk;
  logic        rst;
  ex_to_mem_s  ex;
  logic        stall;
  logic [31:0] bp_mem;
  logic        req_valid;
  logic        req_ready;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        rsp_valid;
  logic [31:0] rdata;
  logic        wb_valid;
  logic        wb_reg_write;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_is_final;
  logic        misalign_err;
  logic        timeout_err;

  typedef struct {
    logic        reg_write;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        is_final;
    logic        chk_data;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  mem_access #(.TIMEOUT_CYCLES(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .ex_to_mem      (ex),
    .stall          (stall),
    .bp_mem         (bp_mem),
    .dmem_req_valid (req_valid),
    .dmem_req_ready (req_ready),
    .dmem_we        (we),
    .dmem_addr      (addr),
    .dmem_wdata     (wdata),
    .dmem_rsp_valid (rsp_valid),
    .dmem_rdata     (rdata),
    .wb_valid       (wb_valid),
    .wb_reg_write   (wb_reg_write),
    .wb_rd          (wb_rd),
    .wb_data        (wb_data),
    .wb_is_final    (wb_is_final),
    .misalign_err   (misalign_err),
    .timeout_err    (timeout_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic set_op(input logic mr, input logic mw, input logic rw, input logic [4:0] rd,
                        input logic [31:0] alu, input logic [31:0] md, input logic fin);
    ex.mem_read   = mr;
    ex.mem_write  = mw;
    ex.reg_write  = rw;
    ex.rd         = rd;
    ex.alu_result = alu;
    ex.mem_data   = md;
    ex.is_final   = fin;
  endtask

  task automatic expect_wb(input logic rw, input logic [4:0] rd, input logic [31:0] data,
                           input logic fin, input logic chkd);
    exp_t e;
    e.reg_write = rw;
    e.rd        = rd;
    e.data      = data;
    e.is_final  = fin;
    e.chk_data  = chkd;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every retirement must match the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && wb_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL wb_unexpected actual=rd%0d expected=none", wb_rd);
      end else begin
        e = exp_q.pop_front();
        chk("wb_reg_write", 32'(wb_reg_write), 32'(e.reg_write));
        chk("wb_rd", 32'(wb_rd), 32'(e.rd));
        chk("wb_is_final", 32'(wb_is_final), 32'(e.is_final));
        if (e.chk_data) chk("wb_data", wb_data, e.data);
      end
    end
  end

  initial begin
    rst       = 1'b0;
    ex        = '0;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    rdata     = 32'd0;
    #2 rst = 1'b1;
    #2;
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_wb_reg_write", 32'(wb_reg_write), 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_req_valid", 32'(req_valid), 32'd0);
    chk("rst_misalign", 32'(misalign_err), 32'd0);
    chk("rst_timeout", 32'(timeout_err), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;

    // ALU op
    set_op(1'b0, 1'b0, 1'b1, 5'd5, 32'h0000_1234, 32'h0, 1'b0);
    expect_wb(1'b1, 5'd5, 32'h0000_1234, 1'b0, 1'b1);
    #3;
    chk("alu_stall", 32'(stall), 32'd0);
    chk("alu_req_valid", 32'(req_valid), 32'd0);
    chk("alu_bp_mem", bp_mem, 32'h0000_1234);
    step();

    // Zero-wait store
    req_ready = 1'b1;
    set_op(1'b0, 1'b1, 1'b1, 5'd7, 32'h0000_0100, 32'hDEAD_BEEF, 1'b1);
    expect_wb(1'b0, 5'd7, 32'h0, 1'b1, 1'b0);
    #3;
    chk("st_req_valid", 32'(req_valid), 32'd1);
    chk("st_we", 32'(we), 32'd1);
    chk("st_addr", addr, 32'h0000_0100);
    chk("st_wdata", wdata, 32'hDEAD_BEEF);
    chk("st_stall", 32'(stall), 32'd0);
    step();

    // Back-to-back ALU op
    req_ready = 1'b0;
    set_op(1'b0, 1'b0, 1'b0, 5'd3, 32'hA5A5_0003, 32'h0, 1'b0);
    expect_wb(1'b0, 5'd3, 32'hA5A5_0003, 1'b0, 1'b1);
    #3;
    chk("b2b_stall", 32'(stall), 32'd0);
    step();

    // Load: ready low 2 cycles, accepted in cycle 2, response in cycle 5
    set_op(1'b1, 1'b0, 1'b1, 5'd9, 32'h0000_0200, 32'h0, 1'b0);
    expect_wb(1'b1, 5'd9, 32'hCAFE_F00D, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      req_ready = (i == 2);
      #3;
      chk("ld_stall", 32'(stall), 32'd1);
      if (i <= 2) begin
        chk("ld_req_valid", 32'(req_valid), 32'd1);
        chk("ld_addr", addr, 32'h0000_0200);
        chk("ld_we", 32'(we), 32'd0);
      end else begin
        chk("ld_req_idle", 32'(req_valid), 32'd0);
      end
      if (i >= 1) chk("ld_bubble", 32'(wb_valid), 32'd0);
      step();
    end
    req_ready = 1'b0;
    rsp_valid = 1'b1;
    rdata     = 32'hCAFE_F00D;
    #3;
    chk("ld_rsp_stall", 32'(stall), 32'd0);
    step();
    rsp_valid = 1'b0;
    rdata     = 32'd0;

    // Misaligned load
    req_ready = 1'b1;
    set_op(1'b1, 1'b0, 1'b1, 5'd4, 32'h0000_0202, 32'h0, 1'b1);
    expect_wb(1'b0, 5'd4, 32'h0, 1'b1, 1'b0);
    #3;
    chk("mis_req_valid", 32'(req_valid), 32'd0);
    chk("mis_stall", 32'(stall), 32'd0);
    step();
    set_op(1'b0, 1'b0, 1'b1, 5'd1, 32'h0000_0011, 32'h0, 1'b0);
    expect_wb(1'b1, 5'd1, 32'h0000_0011, 1'b0, 1'b1);
    #3;
    chk("mis_err_set", 32'(misalign_err), 32'd1);
    step();

    // Misaligned store
    set_op(1'b0, 1'b1, 1'b0, 5'd2, 32'h0000_0301, 32'h1111_2222, 1'b0);
    expect_wb(1'b0, 5'd2, 32'h0, 1'b0, 1'b0);
    #3;
    chk("mis_st_req_valid", 32'(req_valid), 32'd0);
    chk("mis_st_stall", 32'(stall), 32'd0);
    step();

    // Timeout: load accepted, response never arrives
    set_op(1'b1, 1'b0, 1'b1, 5'd6, 32'h0000_0300, 32'h0, 1'b0);
    expect_wb(1'b0, 5'd6, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      #3;
      chk("to_stall", 32'(stall), 32'd1);
      chk("to_req_valid", 32'(req_valid), (i == 0) ? 32'd1 : 32'd0);
      if (i == 0) chk("mis_err_sticky", 32'(misalign_err), 32'd1);
      step();
      req_ready = 1'b0;
    end
    #3;
    chk("to_release", 32'(stall), 32'd0);
    chk("to_err_pre", 32'(timeout_err), 32'd0);
    step();
    set_op(1'b0, 1'b0, 1'b1, 5'd8, 32'h0000_0055, 32'h0, 1'b0);
    expect_wb(1'b1, 5'd8, 32'h0000_0055, 1'b0, 1'b1);
    #3;
    chk("to_err_set", 32'(timeout_err), 32'd1);
    chk("to_after_stall", 32'(stall), 32'd0);
    step();

    // Minimum-cost load after the timeout
    req_ready = 1'b1;
    set_op(1'b1, 1'b0, 1'b1, 5'd10, 32'h0000_0400, 32'h0, 1'b1);
    expect_wb(1'b1, 5'd10, 32'h1234_5678, 1'b1, 1'b1);
    #3;
    chk("ld2_req_valid", 32'(req_valid), 32'd1);
    chk("ld2_stall", 32'(stall), 32'd1);
    step();
    req_ready = 1'b0;
    rsp_valid = 1'b1;
    rdata     = 32'h1234_5678;
    #3;
    chk("ld2_rsp_stall", 32'(stall), 32'd0);
    step();
    rsp_valid = 1'b0;
    rdata     = 32'd0;

    // Reset while waiting in RSP
    req_ready = 1'b1;
    set_op(1'b1, 1'b0, 1'b1, 5'd11, 32'h0000_0500, 32'h0, 1'b0);
    expect_wb(1'b1, 5'd11, 32'h0, 1'b0, 1'b0);
    #3;
    chk("rsp_pre_stall", 32'(stall), 32'd1);
    step();
    req_ready = 1'b0;
    #1;
    chk("rsp_wait_stall", 32'(stall), 32'd1);
    rst = 1'b1;
    exp_q.delete();
    #1;
    chk("mid_rst_req_valid", 32'(req_valid), 32'd0);
    chk("mid_rst_stall", 32'(stall), 32'd0);
    chk("mid_rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("mid_rst_wb_reg_write", 32'(wb_reg_write), 32'd0);
    chk("mid_rst_wb_rd", 32'(wb_rd), 32'd0);
    chk("mid_rst_wb_data", wb_data, 32'd0);
    chk("mid_rst_wb_is_final", 32'(wb_is_final), 32'd0);
    chk("mid_rst_misalign", 32'(misalign_err), 32'd0);
    chk("mid_rst_timeout", 32'(timeout_err), 32'd0);
    step();

    // Late response after reset must be ignored
    rst       = 1'b0;
    rsp_valid = 1'b1;
    rdata     = 32'hBAD0_BAD0;
    set_op(1'b0, 1'b0, 1'b1, 5'd12, 32'h0000_0077, 32'h0, 1'b0);
    expect_wb(1'b1, 5'd12, 32'h0000_0077, 1'b0, 1'b1);
    #3;
    chk("late_rsp_stall", 32'(stall), 32'd0);
    chk("late_rsp_req_valid", 32'(req_valid), 32'd0);
    step();
    rsp_valid = 1'b0;
    rdata     = 32'd0;
    set_op(1'b0, 1'b0, 1'b1, 5'd13, 32'h0000_0099, 32'h0, 1'b1);
    expect_wb(1'b1, 5'd13, 32'h0000_0099, 1'b1, 1'b1);
    #3;
    chk("final_stall", 32'(stall), 32'd0);
    step();
    @(negedge clk);
    #1;
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
